branch_resolve_unit: RTL and testbench

Tracks every fetched instruction's branch prediction (BHT direction plus BTB target) through the ID and EX stages. It compares the prediction against the real outcome in EX and drives the pipeline redirect. One cycle later it issues registered update pulses to the BHT (direction) and the BTB (target). It sits downstream of the BHT/BTB read port in IF and feeds their write ports.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_track_slot.sv | 48 ++++
 rtl/branch_resolve_unit.sv | 189 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction tracking and resolution logic.
package bp_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam int          NUM_SLOTS   = 2;
  localparam int          SLOT_ID     = 0;
  localparam int          SLOT_EX     = 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bp_slot_t;

  typedef enum logic [1:0] {
    NONE,
    DIR,
    TARGET,
    ALIAS
  } mispredict_kind_e;

  function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/bp_track_slot.sv
// One pipeline tracking slot holding an instruction's prediction.
// Clear wins over load, and load wins over hold.
module bp_track_slot
  import bp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic        d_pred_taken,
  input  logic [31:0] d_pred_target,
  output logic        q_valid,
  output logic [31:0] q_pc,
  output logic        q_pred_taken,
  output logic [31:0] q_pred_target
);

  bp_slot_t slot_reg;
  bp_slot_t slot_next;

  always_comb begin
    slot_next = slot_reg;
    if (clear) begin
      slot_next = '0;
    end else if (load) begin
      slot_next.valid       = d_valid;
      slot_next.pc          = d_pc;
      slot_next.pred_taken  = d_pred_taken;
      slot_next.pred_target = d_pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg <= '0;
    end else begin
      slot_reg <= slot_next;
    end
  end

  assign q_valid       = slot_reg.valid;
  assign q_pc          = slot_reg.pc;
  assign q_pred_taken  = slot_reg.pred_taken;
  assign q_pred_target = slot_reg.pred_target;

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries IF-stage predictions through ID/EX, resolves them in EX, drives the
// redirect and issues registered BHT/BTB update pulses plus statistics.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_valid,
  input  logic [31:0]          if_PC,
  input  logic                 if_predicted_taken,
  input  logic [31:0]          if_predicted_target,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 ex_is_branch,
  input  logic                 ex_br_taken,
  input  logic [31:0]          ex_br_target,
  output logic                 redirect,
  output logic [31:0]          redirect_PC,
  output logic                 bht_wr_req,
  output logic [31:0]          bht_wr_PC,
  output logic                 bht_wr_taken,
  output logic                 btb_wr_req,
  output logic [31:0]          btb_wr_PC,
  output logic [31:0]          btb_wr_target,
  output logic                 btb_wr_valid,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic advance;
  logic clear;

  logic [NUM_SLOTS-1:0]       slot_valid;
  logic [NUM_SLOTS-1:0][31:0] slot_pc;
  logic [NUM_SLOTS-1:0]       slot_pred_taken;
  logic [NUM_SLOTS-1:0][31:0] slot_pred_target;

  logic [NUM_SLOTS-1:0]       d_valid;
  logic [NUM_SLOTS-1:0][31:0] d_pc;
  logic [NUM_SLOTS-1:0]       d_pred_taken;
  logic [NUM_SLOTS-1:0][31:0] d_pred_target;

  assign advance = !stall && !flush && !redirect;
  assign clear   = flush || redirect;

  // Slot 0 (ID) loads from IF; each later slot loads from the one before it.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    if (gi == 0) begin : g_head
      assign d_valid[gi]       = if_valid;
      assign d_pc[gi]          = if_PC;
      assign d_pred_taken[gi]  = if_predicted_taken;
      assign d_pred_target[gi] = if_predicted_target;
    end else begin : g_chain
      assign d_valid[gi]       = slot_valid[gi-1];
      assign d_pc[gi]          = slot_pc[gi-1];
      assign d_pred_taken[gi]  = slot_pred_taken[gi-1];
      assign d_pred_target[gi] = slot_pred_target[gi-1];
    end

    bp_track_slot u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (advance),
      .clear        (clear),
      .d_valid      (d_valid[gi]),
      .d_pc         (d_pc[gi]),
      .d_pred_taken (d_pred_taken[gi]),
      .d_pred_target(d_pred_target[gi]),
      .q_valid      (slot_valid[gi]),
      .q_pc         (slot_pc[gi]),
      .q_pred_taken (slot_pred_taken[gi]),
      .q_pred_target(slot_pred_target[gi])
    );
  end

  logic             ex_valid;
  logic [31:0]      ex_pc;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic             resolve;
  mispredict_kind_e mp_kind;
  logic [31:0]      correct_pc;

  assign ex_valid       = slot_valid[SLOT_EX];
  assign ex_pc          = slot_pc[SLOT_EX];
  assign ex_pred_taken  = slot_pred_taken[SLOT_EX];
  assign ex_pred_target = slot_pred_target[SLOT_EX];

  // A flush does not block resolution; only a stall does.
  assign resolve = ex_valid && !stall;

  always_comb begin
    mp_kind    = NONE;
    correct_pc = '0;
    if (resolve) begin
      if (ex_is_branch) begin
        if (ex_br_taken) begin
          correct_pc = ex_br_target;
          if (!ex_pred_taken) begin
            mp_kind = DIR;
          end else if (ex_pred_target != ex_br_target) begin
            mp_kind = TARGET;
          end
        end else if (ex_pred_taken) begin
          mp_kind    = DIR;
          correct_pc = fallthrough_pc(ex_pc);
        end
      end else if (ex_pred_taken) begin
        mp_kind    = ALIAS;
        correct_pc = fallthrough_pc(ex_pc);
      end
    end
  end

  assign redirect    = (mp_kind != NONE);
  assign redirect_PC = redirect ? correct_pc : '0;

  logic bht_req_next;
  logic btb_req_next;

  assign bht_req_next = resolve && ex_is_branch;
  assign btb_req_next = (resolve && ex_is_branch && ex_br_taken) || (mp_kind == ALIAS);

  logic                 bht_wr_req_reg;
  logic [31:0]          bht_wr_pc_reg;
  logic                 bht_wr_taken_reg;
  logic                 btb_wr_req_reg;
  logic [31:0]          btb_wr_pc_reg;
  logic [31:0]          btb_wr_target_reg;
  logic                 btb_wr_valid_reg;
  logic [CNT_WIDTH-1:0] branch_cnt_reg;
  logic [CNT_WIDTH-1:0] mispredict_cnt_reg;

  // Request bits pulse for one cycle; payloads hold until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht_wr_req_reg    <= 1'b0;
      bht_wr_pc_reg     <= '0;
      bht_wr_taken_reg  <= 1'b0;
      btb_wr_req_reg    <= 1'b0;
      btb_wr_pc_reg     <= '0;
      btb_wr_target_reg <= '0;
      btb_wr_valid_reg  <= 1'b0;
    end else begin
      bht_wr_req_reg <= bht_req_next;
      btb_wr_req_reg <= btb_req_next;
      if (bht_req_next) begin
        bht_wr_pc_reg    <= ex_pc;
        bht_wr_taken_reg <= ex_br_taken;
      end
      if (btb_req_next) begin
        btb_wr_pc_reg    <= ex_pc;
        btb_wr_valid_reg <= ex_is_branch;
        if (ex_is_branch) begin
          btb_wr_target_reg <= ex_br_target;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else begin
      if (bht_req_next && (branch_cnt_reg != '1)) begin
        branch_cnt_reg <= branch_cnt_reg + CNT_ONE;
      end
      if (redirect && (mispredict_cnt_reg != '1)) begin
        mispredict_cnt_reg <= mispredict_cnt_reg + CNT_ONE;
      end
    end
  end

  assign bht_wr_req     = bht_wr_req_reg;
  assign bht_wr_PC      = bht_wr_pc_reg;
  assign bht_wr_taken   = bht_wr_taken_reg;
  assign btb_wr_req     = btb_wr_req_reg;
  assign btb_wr_PC      = btb_wr_pc_reg;
  assign btb_wr_target  = btb_wr_target_reg;
  assign btb_wr_valid   = btb_wr_valid_reg;
  assign branch_cnt     = branch_cnt_reg;
  assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_PC;
  logic        if_predicted_taken;
  logic [31:0] if_predicted_target;
  logic        stall;
  logic        flush;
  logic        ex_is_branch;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        redirect;
  logic [31:0] redirect_PC;
  logic        bht_wr_req;
  logic [31:0] bht_wr_PC;
  logic        bht_wr_taken;
  logic        btb_wr_req;
  logic [31:0] btb_wr_PC;
  logic [31:0] btb_wr_target;
  logic        btb_wr_valid;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_WIDTH(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .if_valid           (if_valid),
    .if_PC              (if_PC),
    .if_predicted_taken (if_predicted_taken),
    .if_predicted_target(if_predicted_target),
    .stall              (stall),
    .flush              (flush),
    .ex_is_branch       (ex_is_branch),
    .ex_br_taken        (ex_br_taken),
    .ex_br_target       (ex_br_target),
    .redirect           (redirect),
    .redirect_PC        (redirect_PC),
    .bht_wr_req         (bht_wr_req),
    .bht_wr_PC          (bht_wr_PC),
    .bht_wr_taken       (bht_wr_taken),
    .btb_wr_req         (btb_wr_req),
    .btb_wr_PC          (btb_wr_PC),
    .btb_wr_target      (btb_wr_target),
    .btb_wr_valid       (btb_wr_valid),
    .branch_cnt         (branch_cnt),
    .mispredict_cnt     (mispredict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in IF for a cycle; afterwards it sits in ID.
  task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    if_valid            = 1'b1;
    if_PC               = pc;
    if_predicted_taken  = pt;
    if_predicted_target = tgt;
    step();
    if_valid            = 1'b0;
    if_PC               = '0;
    if_predicted_taken  = 1'b0;
    if_predicted_target = '0;
  endtask

  task automatic ex_set(input logic br, input logic tk, input logic [31:0] tgt);
    ex_is_branch = br;
    ex_br_taken  = tk;
    ex_br_target = tgt;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 0; if_PC = 0; if_predicted_taken = 0; if_predicted_target = 0;
    stall = 0; flush = 0; ex_is_branch = 0; ex_br_taken = 0; ex_br_target = 0;
    step(); step();
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_bht_req", 32'(bht_wr_req), 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mis_cnt", mispredict_cnt, 32'd0);
    rst_n = 1'b1;
    step();

    // Predicted not taken, actually taken to 0x200
    fetch(32'h100, 1'b0, 32'h0); step();
    ex_set(1'b1, 1'b1, 32'h200);
    chk("A_redirect", 32'(redirect), 32'd1);
    chk("A_redirect_pc", redirect_PC, 32'h200);
    step(); ex_set(1'b0, 1'b0, 32'h0);
    chk("A_bht_req", 32'(bht_wr_req), 32'd1);
    chk("A_bht_pc", bht_wr_PC, 32'h100);
    chk("A_bht_taken", 32'(bht_wr_taken), 32'd1);
    chk("A_btb_req", 32'(btb_wr_req), 32'd1);
    chk("A_btb_pc", btb_wr_PC, 32'h100);
    chk("A_btb_target", btb_wr_target, 32'h200);
    chk("A_btb_valid", 32'(btb_wr_valid), 32'd1);
    chk("A_branch_cnt", branch_cnt, 32'd1);
    chk("A_mis_cnt", mispredict_cnt, 32'd1);
    step();
    chk("A_bht_pulse_end", 32'(bht_wr_req), 32'd0);
    $display("step A: pc=100 pred NT, taken to 200");

    // Predicted taken to 0x80, actually not taken
    fetch(32'h40, 1'b1, 32'h80); step();
    ex_set(1'b1, 1'b0, 32'h0);
    chk("B_redirect_pc", redirect_PC, 32'h44);
    step(); ex_set(1'b0, 1'b0, 32'h0);
    chk("B_bht_req", 32'(bht_wr_req), 32'd1);
    chk("B_bht_pc", bht_wr_PC, 32'h40);
    chk("B_bht_taken", 32'(bht_wr_taken), 32'd0);
    chk("B_btb_req", 32'(btb_wr_req), 32'd0);
    chk("B_mis_cnt", mispredict_cnt, 32'd2);
    $display("step B: pc=40 pred T 80, not taken");

    // Predicted taken to 0x80, actually taken to 0x90
    fetch(32'h40, 1'b1, 32'h80); step();
    ex_set(1'b1, 1'b1, 32'h90);
    chk("C_redirect", 32'(redirect), 32'd1);
    chk("C_redirect_pc", redirect_PC, 32'h90);
    step(); ex_set(1'b0, 1'b0, 32'h0);
    chk("C_btb_req", 32'(btb_wr_req), 32'd1);
    chk("C_btb_target", btb_wr_target, 32'h90);
    chk("C_btb_valid", 32'(btb_wr_valid), 32'd1);
    chk("C_branch_cnt", branch_cnt, 32'd3);
    $display("step C: pc=40 pred T 80, taken to 90");

    // Correct prediction still refreshes the BTB
    fetch(32'h40, 1'b1, 32'h90); step();
    ex_set(1'b1, 1'b1, 32'h90);
    chk("D_redirect", 32'(redirect), 32'd0);
    chk("D_redirect_pc", redirect_PC, 32'h0);
    step(); ex_set(1'b0, 1'b0, 32'h0);
    chk("D_btb_req", 32'(btb_wr_req), 32'd1);
    chk("D_branch_cnt", branch_cnt, 32'd4);
    chk("D_mis_cnt", mispredict_cnt, 32'd3);
    $display("step D: pc=40 pred T 90, taken to 90");

    // BTB alias on a non-branch
    fetch(32'h300, 1'b1, 32'h500); step();
    ex_set(1'b0, 1'b0, 32'h0);
    chk("E_redirect_pc", redirect_PC, 32'h304);
    step();
    chk("E_btb_req", 32'(btb_wr_req), 32'd1);
    chk("E_btb_pc", btb_wr_PC, 32'h300);
    chk("E_btb_valid", 32'(btb_wr_valid), 32'd0);
    chk("E_bht_req", 32'(bht_wr_req), 32'd0);
    chk("E_branch_cnt", branch_cnt, 32'd4);
    chk("E_mis_cnt", mispredict_cnt, 32'd4);
    $display("step E: non-branch pc=300 aliased to 500");

    // Stall three cycles with the branch in EX, then release
    fetch(32'h600, 1'b0, 32'h0); step();
    stall = 1'b1;
    ex_set(1'b1, 1'b1, 32'h700);
    for (int i = 0; i < 3; i++) begin
      chk("F_stall_redirect", 32'(redirect), 32'd0);
      step();
      chk("F_stall_bht_req", 32'(bht_wr_req), 32'd0);
    end
    stall = 1'b0;
    #1;
    chk("F_redirect", 32'(redirect), 32'd1);
    chk("F_redirect_pc", redirect_PC, 32'h700);
    step();
    chk("F_bht_req", 32'(bht_wr_req), 32'd1);
    chk("F_bht_pc", bht_wr_PC, 32'h600);
    chk("F_branch_cnt", branch_cnt, 32'd5);
    chk("F_mis_cnt", mispredict_cnt, 32'd5);
    step();
    chk("F_once", 32'(bht_wr_req), 32'd0);
    ex_set(1'b0, 1'b0, 32'h0);
    $display("step F: pc=600 stalled 3 cycles then resolved");

    // Flush while stalled discards the branch
    fetch(32'h800, 1'b1, 32'h900); step();
    stall = 1'b1;
    ex_set(1'b1, 1'b0, 32'h0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    #1;
    chk("G_redirect", 32'(redirect), 32'd0);
    step();
    chk("G_bht_req", 32'(bht_wr_req), 32'd0);
    chk("G_branch_cnt", branch_cnt, 32'd5);
    chk("G_mis_cnt", mispredict_cnt, 32'd5);
    ex_set(1'b0, 1'b0, 32'h0);
    $display("step G: pc=800 flushed during stall");

    // Back-to-back correctly predicted not-taken branches
    fetch(32'hA00, 1'b0, 32'h0);
    fetch(32'hA04, 1'b0, 32'h0);
    ex_set(1'b1, 1'b0, 32'h0);
    chk("H_redirect", 32'(redirect), 32'd0);
    step();
    chk("H_bht_req0", 32'(bht_wr_req), 32'd1);
    chk("H_bht_pc0", bht_wr_PC, 32'hA00);
    step();
    chk("H_bht_req1", 32'(bht_wr_req), 32'd1);
    chk("H_bht_pc1", bht_wr_PC, 32'hA04);
    chk("H_branch_cnt", branch_cnt, 32'd7);
    ex_set(1'b0, 1'b0, 32'h0);
    $display("step H: back-to-back pc=A00,A04");

    // Flush coinciding with a redirect
    fetch(32'hB00, 1'b0, 32'h0);
    fetch(32'hB04, 1'b0, 32'h0);
    flush = 1'b1;
    ex_set(1'b1, 1'b1, 32'hC00);
    chk("I_redirect", 32'(redirect), 32'd1);
    chk("I_redirect_pc", redirect_PC, 32'hC00);
    step();
    flush = 1'b0;
    chk("I_bht_req", 32'(bht_wr_req), 32'd1);
    chk("I_bht_pc", bht_wr_PC, 32'hB00);
    chk("I_mis_cnt", mispredict_cnt, 32'd6);
    chk("I_branch_cnt", branch_cnt, 32'd8);
    #1;
    chk("I_cleared_redirect", 32'(redirect), 32'd0);
    step();
    chk("I_cleared_bht_req", 32'(bht_wr_req), 32'd0);
    chk("I_mis_cnt_after", mispredict_cnt, 32'd6);
    ex_set(1'b0, 1'b0, 32'h0);
    $display("step I: flush with redirect at pc=B00");

    // Asynchronous reset in the middle of a cycle
    fetch(32'hD00, 1'b0, 32'h0); step();
    ex_set(1'b1, 1'b1, 32'hE00);
    chk("J_pre_redirect", 32'(redirect), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("J_redirect", 32'(redirect), 32'd0);
    chk("J_redirect_pc", redirect_PC, 32'h0);
    chk("J_branch_cnt", branch_cnt, 32'd0);
    chk("J_mis_cnt", mispredict_cnt, 32'd0);
    chk("J_bht_pc", bht_wr_PC, 32'h0);
    chk("J_btb_target", btb_wr_target, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("J_post_redirect", 32'(redirect), 32'd0);
    chk("J_post_bht_req", 32'(bht_wr_req), 32'd0);
    ex_set(1'b0, 1'b0, 32'h0);
    $display("step J: async reset mid-stream at pc=D00");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
